// File: rtl/axil_ctrl_master.sv
// Command/response front end driving one AXI4-Lite master port, one transaction at a time.
// Optional response watchdog with late-response drain: define AXIL_CTRL_MASTER_TIMEOUT_EN.
module axil_ctrl_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_axi_ctrl_reg_awaddr,
  output logic [2:0]  m_axi_ctrl_reg_awprot,
  output logic        m_axi_ctrl_reg_awvalid,
  input  logic        m_axi_ctrl_reg_awready,
  output logic [31:0] m_axi_ctrl_reg_wdata,
  output logic [3:0]  m_axi_ctrl_reg_wstrb,
  output logic        m_axi_ctrl_reg_wvalid,
  input  logic        m_axi_ctrl_reg_wready,
  input  logic [1:0]  m_axi_ctrl_reg_bresp,
  input  logic        m_axi_ctrl_reg_bvalid,
  output logic        m_axi_ctrl_reg_bready,
  output logic [31:0] m_axi_ctrl_reg_araddr,
  output logic [2:0]  m_axi_ctrl_reg_arprot,
  output logic        m_axi_ctrl_reg_arvalid,
  input  logic        m_axi_ctrl_reg_arready,
  input  logic [31:0] m_axi_ctrl_reg_rdata,
  input  logic [1:0]  m_axi_ctrl_reg_rresp,
  input  logic        m_axi_ctrl_reg_rvalid,
  output logic        m_axi_ctrl_reg_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t      state_r, state_next_s;
  logic [31:0] addr_r, wdata_r, rsp_rdata_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  rsp_resp_r;
  logic        awvalid_r, wvalid_r, arvalid_r, cmd_ready_r, rsp_valid_r, rsp_write_r;
  logic        cmd_hs_s, b_hs_s, r_hs_s, rsp_hs_s, to_s, timeout_hit_s;
  logic        drain_wr_r, drain_rd_r, drain_wr_next_s, drain_rd_next_s;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axil_ctrl_master: TIMEOUT_CYCLES must be within 2..65535");
  end

  assign cmd_ready              = cmd_ready_r;
  assign rsp_valid              = rsp_valid_r;
  assign rsp_write              = rsp_write_r;
  assign rsp_rdata              = rsp_rdata_r;
  assign rsp_resp               = rsp_resp_r;
  assign m_axi_ctrl_reg_awaddr  = addr_r;
  assign m_axi_ctrl_reg_araddr  = addr_r;
  assign m_axi_ctrl_reg_awprot  = 3'b000;
  assign m_axi_ctrl_reg_arprot  = 3'b000;
  assign m_axi_ctrl_reg_awvalid = awvalid_r;
  assign m_axi_ctrl_reg_wvalid  = wvalid_r;
  assign m_axi_ctrl_reg_arvalid = arvalid_r;
  assign m_axi_ctrl_reg_wdata   = wdata_r;
  assign m_axi_ctrl_reg_wstrb   = wstrb_r;
  // A pending drain keeps the response channel open after the FSM has left it.
  assign m_axi_ctrl_reg_bready  = (state_r == WR_RESP) || drain_wr_r;
  assign m_axi_ctrl_reg_rready  = (state_r == RD_RESP) || drain_rd_r;

  assign cmd_hs_s = cmd_valid && cmd_ready_r;
  assign b_hs_s   = m_axi_ctrl_reg_bvalid && m_axi_ctrl_reg_bready;
  assign r_hs_s   = m_axi_ctrl_reg_rvalid && m_axi_ctrl_reg_rready;
  assign rsp_hs_s = ((state_r == WR_RESP) && b_hs_s) || ((state_r == RD_RESP) && r_hs_s);
  assign to_s     = ((state_r == WR_RESP) || (state_r == RD_RESP)) && !rsp_hs_s && timeout_hit_s;

`ifdef AXIL_CTRL_MASTER_TIMEOUT_EN
  logic [15:0] cnt_r;
  logic        rsp_timeout_r;

  assign timeout_hit_s = (cnt_r == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout   = rsp_timeout_r;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt_r <= 16'd0;
    end else if ((state_r == WR_RESP) || (state_r == RD_RESP)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= 16'd0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rsp_timeout_r <= 1'b0;
      drain_wr_r    <= 1'b0;
      drain_rd_r    <= 1'b0;
    end else begin
      drain_wr_r <= drain_wr_next_s;
      drain_rd_r <= drain_rd_next_s;
      if (to_s) begin
        rsp_timeout_r <= 1'b1;
      end else if (rsp_hs_s) begin
        rsp_timeout_r <= 1'b0;
      end
    end
  end

  // A timed-out channel swallows exactly one late response before new commands are taken.
  always_comb begin
    drain_wr_next_s = drain_wr_r;
    drain_rd_next_s = drain_rd_r;
    if (to_s && (state_r == WR_RESP)) begin
      drain_wr_next_s = 1'b1;
    end else if (drain_wr_r && b_hs_s) begin
      drain_wr_next_s = 1'b0;
    end else begin
      drain_wr_next_s = drain_wr_r;
    end
    if (to_s && (state_r == RD_RESP)) begin
      drain_rd_next_s = 1'b1;
    end else if (drain_rd_r && r_hs_s) begin
      drain_rd_next_s = 1'b0;
    end else begin
      drain_rd_next_s = drain_rd_r;
    end
  end
`else
  assign timeout_hit_s   = 1'b0;
  assign rsp_timeout     = 1'b0;
  assign drain_wr_r      = 1'b0;
  assign drain_rd_r      = 1'b0;
  assign drain_wr_next_s = 1'b0;
  assign drain_rd_next_s = 1'b0;
`endif

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          state_next_s = cmd_write ? WR_REQ : RD_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W may complete in either order or together.
        if ((!awvalid_r || m_axi_ctrl_reg_awready) && (!wvalid_r || m_axi_ctrl_reg_wready)) begin
          state_next_s = WR_RESP;
        end else begin
          state_next_s = WR_REQ;
        end
      end
      RD_REQ: begin
        if (m_axi_ctrl_reg_arready) begin
          state_next_s = RD_RESP;
        end else begin
          state_next_s = RD_REQ;
        end
      end
      WR_RESP, RD_RESP: begin
        if (rsp_hs_s || to_s) begin
          state_next_s = RSP;
        end else begin
          state_next_s = state_r;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RSP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      wstrb_r     <= 4'd0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_resp_r  <= 2'b00;
      rsp_rdata_r <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == IDLE) && !drain_wr_next_s && !drain_rd_next_s;
      if (cmd_hs_s) begin
        addr_r    <= cmd_addr;
        wdata_r   <= cmd_wdata;
        wstrb_r   <= cmd_wstrb;
        awvalid_r <= cmd_write;
        wvalid_r  <= cmd_write;
        arvalid_r <= !cmd_write;
      end else begin
        if (m_axi_ctrl_reg_awready) awvalid_r <= 1'b0;
        if (m_axi_ctrl_reg_wready)  wvalid_r  <= 1'b0;
        if (m_axi_ctrl_reg_arready) arvalid_r <= 1'b0;
      end
      if (rsp_hs_s) begin
        rsp_valid_r <= 1'b1;
        rsp_write_r <= (state_r == WR_RESP);
        rsp_resp_r  <= (state_r == WR_RESP) ? m_axi_ctrl_reg_bresp : m_axi_ctrl_reg_rresp;
        rsp_rdata_r <= (state_r == WR_RESP) ? 32'd0 : m_axi_ctrl_reg_rdata;
      end else if (to_s) begin
        rsp_valid_r <= 1'b1;
        rsp_write_r <= (state_r == WR_RESP);
        rsp_resp_r  <= 2'b10;
        rsp_rdata_r <= 32'd0;
      end else if ((state_r == RSP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Directed bench for axil_ctrl_master: table of transactions against a bench-side AXI4-Lite
// responder, plus hand-written reset, backpressure and (with the macro) timeout/drain sequences.
module tb_axil_ctrl_master;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic [3:0]  cmd_wstrb = 4'd0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'd0;

  axil_ctrl_master #(.TIMEOUT_CYCLES(8)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_ctrl_reg_awaddr(awaddr), .m_axi_ctrl_reg_awprot(awprot),
    .m_axi_ctrl_reg_awvalid(awvalid), .m_axi_ctrl_reg_awready(awready),
    .m_axi_ctrl_reg_wdata(wdata), .m_axi_ctrl_reg_wstrb(wstrb),
    .m_axi_ctrl_reg_wvalid(wvalid), .m_axi_ctrl_reg_wready(wready),
    .m_axi_ctrl_reg_bresp(bresp), .m_axi_ctrl_reg_bvalid(bvalid), .m_axi_ctrl_reg_bready(bready),
    .m_axi_ctrl_reg_araddr(araddr), .m_axi_ctrl_reg_arprot(arprot),
    .m_axi_ctrl_reg_arvalid(arvalid), .m_axi_ctrl_reg_arready(arready),
    .m_axi_ctrl_reg_rdata(rdata), .m_axi_ctrl_reg_rresp(rresp),
    .m_axi_ctrl_reg_rvalid(rvalid), .m_axi_ctrl_reg_rready(rready)
  );

  // Responder configuration, set per transaction by the stimulus.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 0;
  logic [1:0]  code = 2'b00;
  logic [31:0] rd_val = 32'd0;
  logic        no_r = 1'b0;

  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, b_iss, r_iss;
  int          stab_err = 0, hs_cyc = 0, ar_hs_cyc = 0;
  logic [31:0] aw_seen, w_seen, ar_seen;
  logic [3:0]  s_seen;
  logic        awv_p, awr_p, wv_p, wr_p, arv_p, arr_p, bv_p, br_p, rv_p, rr_p;

  // Responder acts on the falling edge; *_p hold what was present at the rising edge in between.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; b_iss = 0; r_iss = 0;
      awv_p = 1'b0; awr_p = 1'b0; wv_p = 1'b0; wr_p = 1'b0; arv_p = 1'b0; arr_p = 1'b0;
      bv_p = 1'b0; br_p = 1'b0; rv_p = 1'b0; rr_p = 1'b0;
    end else begin
      if (awv_p && awr_p) begin
        aw_cnt++; awready = 1'b0; aw_wait = 0;
      end else if (awvalid) begin
        if (!awv_p) aw_seen = awaddr; else if (awaddr !== aw_seen) stab_err++;
        if (aw_wait >= aw_dly) awready = 1'b1; else aw_wait++;
      end else if (awv_p) stab_err++;
      if (wv_p && wr_p) begin
        w_cnt++; wready = 1'b0; w_wait = 0;
      end else if (wvalid) begin
        if (!wv_p) begin w_seen = wdata; s_seen = wstrb; end
        else if (wdata !== w_seen || wstrb !== s_seen) stab_err++;
        if (w_wait >= w_dly) wready = 1'b1; else w_wait++;
      end else if (wv_p) stab_err++;
      if (arv_p && arr_p) begin
        ar_cnt++; arready = 1'b0; ar_wait = 0; ar_hs_cyc = cyc;
      end else if (arvalid) begin
        if (!arv_p) ar_seen = araddr; else if (araddr !== ar_seen) stab_err++;
        if (ar_wait >= ar_dly) arready = 1'b1; else ar_wait++;
      end else if (arv_p) stab_err++;
      if (bv_p && br_p) begin b_cnt++; hs_cyc = cyc; bvalid = 1'b0; end
      if (!bvalid && aw_cnt > b_iss && w_cnt > b_iss) begin
        if (b_wait >= rsp_dly) begin bvalid = 1'b1; bresp = code; b_iss++; b_wait = 0; end
        else b_wait++;
      end
      if (rv_p && rr_p) begin r_cnt++; hs_cyc = cyc; rvalid = 1'b0; end
      if (!rvalid && ar_cnt > r_iss && !no_r) begin
        if (r_wait >= rsp_dly) begin rvalid = 1'b1; rdata = rd_val; rresp = code; r_iss++; r_wait = 0; end
        else r_wait++;
      end
      awv_p = awvalid; awr_p = awready; wv_p = wvalid; wr_p = wready; arv_p = arvalid; arr_p = arready;
      bv_p = bvalid; br_p = bready; rv_p = rvalid; rr_p = rready;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    int aw_d; int w_d; int ar_d; int rsp_d; int hold;
    logic [1:0] code; logic [31:0] rd;
    logic exp_wr; logic [1:0] exp_resp; logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string nm);
    int t, a0, w0, ar0, b0, r0, s0, rc, herr;
    logic [35:0] held;
    logic [19:0] cnts;
    a0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt; b0 = b_cnt; r0 = r_cnt; s0 = stab_err;
    aw_dly = v.aw_d; w_dly = v.w_d; ar_dly = v.ar_d; rsp_dly = v.rsp_d; code = v.code; rd_val = v.rd;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge ap_clk); t++; end
    check({nm, " cmd accepted"}, 64'(t < 50), 64'd1);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    check({nm, " aw/w/ar valid next cycle"}, {awvalid, wvalid, arvalid}, v.wr ? 64'd6 : 64'd1);
    t = 0;
    while (rsp_valid !== 1'b1 && t < 200) begin @(negedge ap_clk); t++; end
    rc = cyc;
    check({nm, " rsp arrives"}, 64'(t < 200), 64'd1);
    held = {rsp_write, rsp_resp, rsp_rdata, rsp_timeout};
    check({nm, " rsp fields"}, held, {v.exp_wr, v.exp_resp, v.exp_rdata, 1'b0});
    herr = 0;
    for (int k = 0; k < v.hold; k++) begin
      @(negedge ap_clk);
      if (rsp_valid !== 1'b1 || {rsp_write, rsp_resp, rsp_rdata, rsp_timeout} !== held || cmd_ready !== 1'b0) herr++;
    end
    check({nm, " rsp held while stalled"}, herr, 0);
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    check({nm, " cmd_ready/rsp_valid after rsp"}, {cmd_ready, rsp_valid}, 64'd2);
    @(negedge ap_clk);
    cnts = {4'(aw_cnt - a0), 4'(w_cnt - w0), 4'(ar_cnt - ar0), 4'(b_cnt - b0), 4'(r_cnt - r0)};
    check({nm, " handshake counts aw,w,ar,b,r"}, cnts, v.wr ? 64'h11010 : 64'h00101);
    check({nm, " rsp cycle after B/R handshake"}, rc, hs_cyc);
    if (v.wr) check({nm, " aw/w payload"}, {aw_seen, s_seen}, {v.addr, v.wstrb});
    else      check({nm, " ar payload"}, ar_seen, v.addr);
    if (v.wr) check({nm, " wdata"}, w_seen, v.wdata);
    check({nm, " payload/valid stable"}, stab_err - s0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, r0, herr;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         1'b1, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 5, 0, 0, 2'b00, 32'h1234_5678, 1'b0, 2'b00, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h3, 3, 0, 0, 0, 0, 2'b01, 32'h0,         1'b1, 2'b01, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0104, 32'h0000_0001, 4'hC, 0, 3, 0, 2, 0, 2'b11, 32'h0,         1'b1, 2'b11, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 0, 0, 0, 2, 0, 2'b10, 32'hCAFE_F00D, 1'b0, 2'b10, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'h1, 0, 0, 0, 1, 10, 2'b00, 32'h0,        1'b1, 2'b00, 32'h0};
    vecs[6] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 1, 4, 3, 2'b00, 32'hFFFF_0000, 1'b0, 2'b00, 32'hFFFF_0000};

    repeat (3) @(negedge ap_clk);
    check("reset outputs", {cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    check("reset prot/timeout", {awprot, arprot, rsp_timeout}, 64'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("cmd_ready after reset release", cmd_ready, 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef AXIL_CTRL_MASTER_TIMEOUT_EN
    no_r = 1'b1; rsp_dly = 0; ar_dly = 0; code = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge ap_clk); t++; end
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    t = 0;
    while (rsp_valid !== 1'b1 && t < 100) begin @(negedge ap_clk); t++; end
    check("timeout rsp arrives", 64'(t < 100), 64'd1);
    check("timeout latency in RD_RESP", cyc - ar_hs_cyc, 64'd8);
    check("timeout rsp fields", {rsp_write, rsp_resp, rsp_rdata, rsp_timeout}, {1'b0, 2'b10, 32'h0, 1'b1});
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    check("drain blocks cmd, keeps rready", {cmd_ready, rready}, 64'd1);
    herr = 0;
    repeat (3) begin @(negedge ap_clk); if (rsp_valid !== 1'b0) herr++; end
    rd_val = 32'hBAD0_BAD0; rsp_dly = 2; r0 = r_cnt; no_r = 1'b0;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 30) begin @(negedge ap_clk); if (rsp_valid !== 1'b0) herr++; t++; end
    check("drain completes", 64'(t < 30), 64'd1);
    check("late rvalid not reported", herr, 0);
    @(negedge ap_clk);
    check("late rvalid accepted once", r_cnt - r0, 64'd1);
    run_vec(vecs[1], "read after drain");
`endif

    aw_dly = 100000; w_dly = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin @(negedge ap_clk); t++; end
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("awvalid stalled in WR_REQ", awvalid, 64'd1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("mid-write reset clears", {awvalid, wvalid, arvalid, rsp_valid, cmd_ready}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    aw_dly = 0;
    @(negedge ap_clk);
    check("cmd_ready after mid reset, no rsp", {cmd_ready, rsp_valid}, 64'd2);
    run_vec(vecs[0], "write after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_ctrl_master.md
AXIL_CTRL_MASTER -- requirements
Module: axil_ctrl_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: ap_clk and ap_rst_n.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 1024, giving the response-phase watchdog limit in ap_clk cycles (range 2..65535).
REQ-003 ap_clk  in  1  sole clock; all flops on rising edge.
REQ-004 ap_rst_n  in  1  synchronous active-low reset.
REQ-005 cmd_valid, cmd_ready  in/out  1 each  command handshake.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  32  target address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_wstrb  in  4  write byte strobes.
REQ-010 rsp_valid, rsp_ready  out/in  1 each  response handshake.
REQ-011 rsp_write  out  1  type of the completed command.
REQ-012 rsp_rdata  out  32  read data; 0 for writes.
REQ-013 rsp_resp  out  2  AXI response code.
REQ-014 rsp_timeout  out  1  watchdog expired.
REQ-015 The AXI4-Lite master port m_axi_ctrl_reg_* SHALL carry awaddr[31:0], awprot[2:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr[31:0], arprot[2:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid and rready, and SHALL be directly connectable to an s_axi_ctrl_reg responder.

Function
REQ-016 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP; at most one transaction SHALL be outstanding.
REQ-017 cmd_ready SHALL be 1 only in IDLE with no drain pending (REQ-026).
REQ-018 On a cmd_valid&cmd_ready handshake in cycle N, the block SHALL register the address, data and strobes, and in cycle N+1 SHALL assert either awvalid and wvalid (write) or arvalid (read).
REQ-019 In WR_REQ, awvalid and wvalid SHALL deassert independently on their own handshakes; the FSM SHALL move to WR_RESP once both have completed, in either order or in the same cycle.
REQ-020 In RD_REQ, arvalid SHALL deassert on the arready handshake, then the FSM SHALL move to RD_RESP.
REQ-021 bready SHALL be 1 only in WR_RESP or while a write drain is pending; rready SHALL be 1 only in RD_RESP or while a read drain is pending.
REQ-022 On a B or R handshake in cycle M, the block SHALL assert rsp_valid in cycle M+1 with the resp/rdata captured, rsp_timeout=0, in state RSP.
REQ-023 rsp_valid and all rsp_* fields SHALL hold stable until rsp_ready; the FSM SHALL then return to IDLE, with cmd_ready=1 in the next cycle.
REQ-024 AW/W/AR valid and payload SHALL never change before their handshake, per AXI rules; awprot and arprot SHALL be constant 3'b000.
REQ-025 The address phase SHALL have no timeout: the block SHALL wait indefinitely for awready, wready and arready.
REQ-026 Drain (timeout build only): after a timeout, the block SHALL set a per-channel drain flag, accept and discard the next bvalid or rvalid on that channel without reporting it, then clear the flag.

Reset
REQ-027 While ap_rst_n=0 at a clock edge, the block SHALL set: FSM to IDLE; cmd_ready, awvalid, wvalid, arvalid, bready, rready and rsp_valid to 0; all address, data, rsp fields and the counter to 0; drain flags cleared.
REQ-028 cmd_ready SHALL first rise in the cycle after ap_rst_n returns to 1.
REQ-029 A reset in the middle of a transaction SHALL abandon it without producing a response.

Configuration
REQ-030 With macro AXIL_CTRL_MASTER_TIMEOUT_EN defined:
- a 16-bit counter SHALL clear on entry to WR_RESP or RD_RESP and increment each cycle in those states;
- when it reaches TIMEOUT_CYCLES-1 with no handshake, the block SHALL go to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0;
- a handshake in that same cycle SHALL win and be reported as a normal response.
REQ-031 Without the macro, the counter and drain logic SHALL be absent, rsp_timeout SHALL be tied to 0, and response phases SHALL wait indefinitely.

Verification
REQ-032 Write 0x0000_0010 <- 0xDEAD_BEEF, wstrb 0xF, responder with zero-wait awready/wready and bresp=0 -> aw/w seen once with those values; rsp_valid with rsp_write=1, rsp_resp=0, rsp_rdata=0.
REQ-033 Read 0x0000_0020, responder returns rdata 0x1234_5678 and rresp=0 after a 5-cycle arready delay -> rsp_rdata=0x1234_5678, rsp_write=0; arvalid held stable for all 5 stall cycles.
REQ-034 Write with wready arriving 3 cycles before awready, then the reverse order -> exactly one B handshake and one response in each case.
REQ-035 rsp_ready held 0 for 10 cycles -> rsp_* stable; cmd_ready=0 throughout; cmd_ready=1 in the cycle after rsp_ready.
REQ-036 TIMEOUT_EN build, TIMEOUT_CYCLES=8, read with rvalid never asserted -> response after 8 cycles in RD_RESP with rsp_resp=2'b10 and rsp_timeout=1; a late rvalid is drained and not reported; the next read completes normally.
REQ-037 Reset pulsed while in WR_REQ -> all valids 0 in the next cycle, no rsp_valid, and cmd_ready=1 the cycle after reset is released.
